round_sequencer: RTL

Central game-flow controller for the raccoon crossing game. It owns lives, level and the run/hit/level-up/end sequencing that the car, raccoon and display blocks consume. It converts the raw, multi-cycle collision level into exactly one life loss per hit, freezes the playfield during hit and level-up pauses, and issues respawn pulses to the raccoon controller. It replaces ad-hoc lives and level bookkeeping in `top` with a single registered source of truth.

---
 rtl/game_pkg.sv | 42 ++++
 rtl/round_sequencer_if.sv | 25 ++
 rtl/round_sequencer_pause_timer.sv | 31 +++
 rtl/round_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding, o_Game_State codes and the
// default cycle constants used by the sequencer, car and video blocks.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_HIT,
    ST_LVL_UP,
    ST_OVER,
    ST_WIN
  } state_e;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_RUN  = 2'b01;
  localparam logic [1:0] GS_WIN  = 2'b10;
  localparam logic [1:0] GS_OVER = 2'b11;

  localparam int unsigned DEF_HIT_CYCLES       = 12_500_000;
  localparam int unsigned DEF_INVULN_CYCLES    = 25_000_000;
  localparam int unsigned DEF_LVL_PAUSE_CYCLES = 6_250_000;
  localparam int unsigned DEF_BLINK_CYCLES     = 3_125_000;
  localparam int unsigned DEF_START_LIVES      = 3;
  localparam int unsigned DEF_MAX_LEVEL        = 9;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // RUN, HIT and LVL_UP all report as "running".
  function automatic logic [1:0] game_state_of(state_e s);
    case (s)
      ST_IDLE: return GS_IDLE;
      ST_WIN:  return GS_WIN;
      ST_OVER: return GS_OVER;
      default: return GS_RUN;
    endcase
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Game-flow bundle between the sequencer and its consumers.
//   i_Start/i_Collision/i_Goal : requests into the sequencer
//   o_*                        : registered game state out of the sequencer
interface round_sequencer_if;
  logic       i_Start;
  logic       i_Collision;
  logic       i_Goal;
  logic [1:0] o_Game_State;
  logic [1:0] o_Lives;
  logic [3:0] o_Level;
  logic       o_Freeze;
  logic       o_Respawn;
  logic       o_Invuln;
  logic       o_Blink;

  modport master (
    output i_Start, i_Collision, i_Goal,
    input  o_Game_State, o_Lives, o_Level, o_Freeze, o_Respawn, o_Invuln, o_Blink
  );

  modport slave (
    input  i_Start, i_Collision, i_Goal,
    output o_Game_State, o_Lives, o_Level, o_Freeze, o_Respawn, o_Invuln, o_Blink
  );
endinterface

// File: rtl/round_sequencer_pause_timer.sv
// Loadable down-counter. load wins over en; the count parks at zero.
//   i_Clk, i_Rst_L : clock, async active-low reset
//   load, load_val : restart the count from load_val
//   en             : decrement by one while non-zero
//   done_c         : count is zero (combinational)
module pause_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/round_sequencer.sv
// Central game-flow controller: lives, level and run/hit/level-up/end
// sequencing, one life lost per collision episode, freeze and respawn control.
//   i_Clk, i_Rst_L : 25 MHz clock, async active-low reset
//   bus (slave)    : start/collision/goal in; state, lives, level, freeze,
//                    respawn, invuln, blink out (all registered)
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned HIT_CYCLES       = DEF_HIT_CYCLES,
  parameter int unsigned INVULN_CYCLES    = DEF_INVULN_CYCLES,
  parameter int unsigned LVL_PAUSE_CYCLES = DEF_LVL_PAUSE_CYCLES,
  parameter int unsigned BLINK_CYCLES     = DEF_BLINK_CYCLES,
  parameter int unsigned START_LIVES      = DEF_START_LIVES,
  parameter int unsigned MAX_LEVEL        = DEF_MAX_LEVEL
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  round_sequencer_if.slave bus
);

  localparam int unsigned TW = $clog2(max3(HIT_CYCLES, INVULN_CYCLES, LVL_PAUSE_CYCLES) + 1);
  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

  state_e        state_q, state_d;
  logic [1:0]    gs_q, gs_d;
  logic [1:0]    lives_q, lives_d;
  logic [3:0]    level_q, level_d;
  logic          freeze_q, freeze_d;
  logic          respawn_q, respawn_d;
  logic          invuln_q, invuln_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          start_q;
  logic          start_edge_c;

  logic          pause_load_c, pause_en_c, pause_done_c;
  logic [TW-1:0] pause_val_c;
  logic          inv_load_c, inv_en_c, inv_done_c;

  assign start_edge_c = bus.i_Start & ~start_q;

  // Timers are loaded with N-1 so the owning state lasts exactly N cycles.
  pause_timer #(.W(TW)) u_pause (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .load     (pause_load_c),
    .load_val (pause_val_c),
    .en       (pause_en_c),
    .done_c   (pause_done_c)
  );

  pause_timer #(.W(TW)) u_invuln (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .load     (inv_load_c),
    .load_val (TW'(INVULN_CYCLES - 1)),
    .en       (inv_en_c),
    .done_c   (inv_done_c)
  );

  // State and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      gs_q        <= GS_IDLE;
      lives_q     <= 2'(START_LIVES);
      level_q     <= '0;
      freeze_q    <= 1'b1;
      respawn_q   <= 1'b0;
      invuln_q    <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gs_q        <= gs_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      freeze_q    <= freeze_d;
      respawn_q   <= respawn_d;
      invuln_q    <= invuln_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      start_q     <= bus.i_Start;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    respawn_d    = 1'b0;
    invuln_d     = invuln_q;
    blink_d      = blink_q;
    blink_cnt_d  = blink_cnt_q;
    pause_load_c = 1'b0;
    pause_val_c  = '0;
    pause_en_c   = 1'b0;
    inv_load_c   = 1'b0;
    inv_en_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          lives_d   = 2'(START_LIVES);
          level_d   = '0;
          respawn_d = 1'b1;
          state_d   = ST_RUN;
        end
      end

      // Goal is only evaluated here, so it is ignored whenever frozen.
      ST_RUN: begin
        if (bus.i_Collision && !invuln_q) begin
          if (lives_q <= 2'd1) begin
            lives_d  = '0;
            invuln_d = 1'b0;
            state_d  = ST_OVER;
          end else begin
            lives_d      = lives_q - 2'd1;
            pause_load_c = 1'b1;
            pause_val_c  = TW'(HIT_CYCLES - 1);
            blink_d      = 1'b1;
            blink_cnt_d  = BW'(BLINK_CYCLES - 1);
            state_d      = ST_HIT;
          end
        end else if (bus.i_Goal) begin
          invuln_d = 1'b0;
          if (level_q >= 4'(MAX_LEVEL)) begin
            state_d = ST_WIN;
          end else begin
            level_d      = level_q + 4'd1;
            pause_load_c = 1'b1;
            pause_val_c  = TW'(LVL_PAUSE_CYCLES - 1);
            state_d      = ST_LVL_UP;
          end
        end else if (invuln_q) begin
          if (inv_done_c) begin
            invuln_d = 1'b0;
          end else begin
            inv_en_c = 1'b1;
          end
        end
      end

      ST_HIT: begin
        if (pause_done_c) begin
          respawn_d  = 1'b1;
          invuln_d   = 1'b1;
          inv_load_c = 1'b1;
          blink_d    = 1'b0;
          state_d    = ST_RUN;
        end else begin
          pause_en_c = 1'b1;
          if (blink_cnt_q == '0) begin
            blink_d     = ~blink_q;
            blink_cnt_d = BW'(BLINK_CYCLES - 1);
          end else begin
            blink_cnt_d = blink_cnt_q - BW'(1);
          end
        end
      end

      ST_LVL_UP: begin
        if (pause_done_c) begin
          respawn_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          pause_en_c = 1'b1;
        end
      end

      ST_OVER, ST_WIN: begin
        if (start_edge_c) begin
          lives_d = 2'(START_LIVES);
          level_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    freeze_d = (state_d != ST_RUN);
    gs_d     = game_state_of(state_d);
  end

  assign bus.o_Game_State = gs_q;
  assign bus.o_Lives      = lives_q;
  assign bus.o_Level      = level_q;
  assign bus.o_Freeze     = freeze_q;
  assign bus.o_Respawn    = respawn_q;
  assign bus.o_Invuln     = invuln_q;
  assign bus.o_Blink      = blink_q;

endmodule
